clk_div_sched: RTL and testbench
================================

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: start  input  1  request to begin a divider run (sampled on clk).
REQ-004 SHALL have ports: stop  input  1  request to end a run at the next div16 boundary.
REQ-005 SHALL have ports: mask  input  4  selects phases ANDed into y: bit0=div2, bit1=div4, bit2=div8, bit3=div16.
REQ-006 SHALL have ports: phase  output  4  divided levels: bit0=div2, bit1=div4, bit2=div8, bit3=div16.
REQ-007 SHALL have ports: tick  output  4  one-cycle pulse on the cycle before phase[i] toggles.
REQ-008 SHALL have ports: y  output  1  AND of the phases selected by the latched mask.
REQ-009 SHALL have ports: busy  output  1  high in RUN or DRAIN.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse on return to IDLE after DRAIN.
REQ-011 SHALL have ports: periods  output  8  count of completed div16 periods in the current/last run.

Function
REQ-012 SHALL be a single-clock design; no derived clocks and no logic clocked by phase bits (the divider uses enables only).
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-014 IDLE + start at an edge: SHALL go to RUN, set cnt=0, latch mask into mask_q, clear periods.
REQ-015 IDLE: stop SHALL be ignored; cnt SHALL hold 0.
REQ-016 RUN/DRAIN: cnt (4-bit) SHALL increment by 1 every edge, wrapping 15->0.
REQ-017 phase SHALL equal cnt (registered); div2 period 2 cycles, div16 period 16 cycles.
REQ-018 tick[i] SHALL be combinational: busy AND cnt[i:0] all ones; tick[3] is high only when cnt==15.
REQ-019 y SHALL equal AND over i of (phase[i] OR NOT mask_q[i]) when mask_q!=0; y SHALL be 0 when mask_q==0 or in IDLE.
REQ-020 RUN + stop at an edge: SHALL go to DRAIN; counting continues unchanged.
REQ-021 RUN with start and stop both high: stop SHALL win (go to DRAIN); start in RUN/DRAIN SHALL be ignored.
REQ-022 DRAIN at an edge with cnt==15: SHALL go to IDLE with cnt=0, and done=1 for exactly the following cycle.
REQ-023 RUN + stop at an edge with cnt==15: SHALL go to DRAIN (not IDLE); DRAIN then lasts a full 16 cycles.
REQ-024 Each 15->0 wrap in RUN or DRAIN SHALL increment periods, saturating at 255; periods holds its value in IDLE.
REQ-025 mask changes during RUN/DRAIN SHALL have no effect until the next start.
REQ-026 done SHALL be registered; busy SHALL be decoded from state.

Reset
REQ-027 reset high SHALL asynchronously force IDLE, cnt=0, mask_q=0, periods=0, done=0; hence phase=0, tick=0, y=0, busy=0.
REQ-028 reset asserted mid-RUN or mid-DRAIN SHALL abort immediately with no done pulse.
REQ-029 After reset deassertion, the first start SHALL be honoured on the first rising edge at which it is sampled high.

Verification
REQ-030 start pulse, mask=4'b0101 -> busy next cycle; phase steps 0,1,2,...,15,0; y=1 only when cnt in {5,7,13,15}.
REQ-031 Run 40 cycles, then check tick -> tick[0] every 2nd cycle, tick[3] only at cnt==15; periods==2 after 40 cycles (wraps at cycles 16 and 32).
REQ-032 stop pulse at cnt==6 -> DRAIN; IDLE reached after the edge at cnt==15; done high exactly 1 cycle; phase==0 thereafter.
REQ-033 start and stop high together in RUN at cnt==15 -> DRAIN for 16 more cycles, then done; periods incremented twice.
REQ-034 reset pulsed at cnt==9 in RUN -> all outputs 0 immediately (before next edge); no done; start next cycle restarts from cnt=0.
REQ-035 mask=0 run, and 300-period run -> y stays 0 throughout; periods saturates at 255.

Source files
------------

// File: rtl/clk_div_sched.sv
// Scheduled divide-by-2/4/8/16 generator on a single clock with start/stop control.
// A 4-bit counter drives the phase outputs, and a drain state finishes the current div16 period.
module clk_div_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] mask,
  output logic [3:0] phase,
  output logic [3:0] tick,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] periods
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   mask_q;
  logic               wrap;

  assign wrap = (cnt == {CNT_W{1'b1}});

  // Control FSM, counter, period count and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mask_q  <= '0;
      periods <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            mask_q  <= mask;
            periods <= '0;
          end
        end
        RUN, DRAIN: begin
          cnt <= cnt + CNT_W'(1);
          if (wrap && (periods != {PER_W{1'b1}})) begin
            periods <= periods + PER_W'(1);
          end
          // The drain always ends on a wrap, so cnt returns to 0 as it enters IDLE
          if ((state == DRAIN) && wrap) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if ((state == RUN) && stop) begin
            state <= DRAIN;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign phase = cnt;

  // Each tick marks the last cycle before the matching phase bit toggles
  assign tick[0] = busy & cnt[0];
  assign tick[1] = busy & (&cnt[1:0]);
  assign tick[2] = busy & (&cnt[2:0]);
  assign tick[3] = busy & (&cnt[3:0]);

  assign y = busy & (mask_q != '0) & (&(cnt | ~mask_q));

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed vector table, corner sequences and random traffic
// compared against a cycle-count reference model.
module tb_clk_div_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] mask;
  logic [3:0] phase;
  logic [3:0] tick;
  logic       y;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  int checks = 0;
  int errors = 0;

  // Reference model: time elapsed in the run, drain flag, latched mask, wrap count
  bit       m_busy;
  bit       m_drain;
  bit       m_done;
  int       m_pos;
  int       m_periods;
  bit [3:0] m_mq;

  clk_div_sched dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .mask    (mask),
    .phase   (phase),
    .tick    (tick),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .periods (periods)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic [3:0] mask;
    int         reps;
    logic       busy;
    logic [3:0] phase;
    logic       y;
    logic       done;
    int         periods;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_done = 0; m_pos = 0; m_periods = 0; m_mq = 4'd0;
  endtask

  // Advance the model by one clock edge using the sampled inputs
  task automatic model_edge(input bit s, input bit p, input bit [3:0] mk);
    bit was_last;
    if (!m_busy) begin
      m_done = 0;
      if (s) begin
        m_busy = 1; m_drain = 0; m_pos = 0; m_mq = mk; m_periods = 0;
      end
    end else begin
      m_done = 0;
      was_last = ((m_pos % 16) == 15);
      m_pos++;
      if (was_last && m_periods < 255) m_periods++;
      if (m_drain && was_last) begin
        m_busy = 0; m_drain = 0; m_pos = 0; m_done = 1;
      end else if (!m_drain && p) begin
        m_drain = 1;
      end
    end
  endtask

  task automatic compare_all();
    int       c;
    bit [3:0] et;
    bit       ey;
    c  = m_busy ? (m_pos % 16) : 0;
    for (int i = 0; i < 4; i++) begin
      int per;
      per   = 2 << i;
      et[i] = m_busy && ((m_pos % per) == per - 1);
    end
    ey = m_busy && (m_mq != 0) && ((c & int'(m_mq)) == int'(m_mq));
    chk("phase",   int'(phase),   c);
    chk("tick",    int'(tick),    int'(et));
    chk("y",       int'(y),       int'(ey));
    chk("busy",    int'(busy),    int'(m_busy));
    chk("done",    int'(done),    int'(m_done));
    chk("periods", int'(periods), m_periods);
  endtask

  // Called and returns at a falling edge: drive, clock, compare
  task automatic step(input bit s, input bit p, input bit [3:0] mk);
    start = s; stop = p; mask = mk;
    @(posedge clk);
    model_edge(s, p, mk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse inside a cycle; outputs must clear before any edge
  task automatic pulse_reset();
    start = 0; stop = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_phase",   int'(phase),   0);
    chk("rst_tick",    int'(tick),    0);
    chk("rst_y",       int'(y),       0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_periods", int'(periods), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; mask = 4'd0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // start/stop/mask/reps -> busy/phase/y/done/periods after the last rep
    tbl[0]  = '{1'b1, 1'b0, 4'h5, 1,  1'b1, 4'd0,  1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 4'hF, 5,  1'b1, 4'd5,  1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 1,  1'b1, 4'd6,  1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 9,  1'b1, 4'd15, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 1,  1'b0, 4'd0,  1'b0, 1'b1, 1};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 1,  1'b0, 4'd0,  1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0, 1'b1, 4'h3, 1,  1'b0, 4'd0,  1'b0, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b1, 4'h0, 1,  1'b1, 4'd0,  1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 15, 1'b1, 4'd15, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 1,  1'b1, 4'd0,  1'b0, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 15, 1'b1, 4'd15, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 1,  1'b0, 4'd0,  1'b0, 1'b1, 2};

    for (int k = 0; k < 12; k++) begin
      for (int r = 0; r < tbl[k].reps; r++) step(tbl[k].start, tbl[k].stop, tbl[k].mask);
      chk($sformatf("tbl%0d_busy", k),    int'(busy),    int'(tbl[k].busy));
      chk($sformatf("tbl%0d_phase", k),   int'(phase),   int'(tbl[k].phase));
      chk($sformatf("tbl%0d_y", k),       int'(y),       int'(tbl[k].y));
      chk($sformatf("tbl%0d_done", k),    int'(done),    int'(tbl[k].done));
      chk($sformatf("tbl%0d_periods", k), int'(periods), tbl[k].periods);
    end

    // 40-cycle run: two completed periods, tick pattern checked every cycle
    step(1, 0, 4'h9);
    for (int i = 0; i < 40; i++) step(0, 0, 4'h0);
    chk("run40_periods", int'(periods), 2);
    chk("run40_phase",   int'(phase),   8);
    pulse_reset();

    // Reset aborts mid-run at cnt 9, no done, restart from 0
    step(1, 0, 4'hF);
    for (int i = 0; i < 9; i++) step(0, 0, 4'hF);
    chk("pre_rst_phase", int'(phase), 9);
    pulse_reset();
    step(1, 0, 4'h2);
    chk("restart_phase", int'(phase), 0);
    chk("restart_busy",  int'(busy),  1);
    step(0, 0, 4'h0);
    chk("restart_phase1", int'(phase), 1);
    chk("restart_done",   int'(done),  0);
    pulse_reset();

    // Long mask=0 run: y never rises, periods saturates
    step(1, 0, 4'h0);
    for (int i = 0; i < 300 * 16; i++) step(0, 0, 4'hF);
    chk("sat_periods", int'(periods), 255);
    step(0, 1, 4'hF);
    for (int i = 0; i < 16; i++) step(0, 0, 4'hF);
    chk("sat_idle_busy",    int'(busy),    0);
    chk("sat_idle_periods", int'(periods), 255);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
